// File: rtl/pdp8_tt_uart.sv
// pdp8_tt_uart -- serial side of the PDP-8 console teletype interface.
//
// Accepts characters from the console device over a tx_req/tx_ack handshake into a
// one-deep holding register and serialises them on tx_out. Deserialises rx_in into a
// one-deep receive register offered to the console device via rx_empty/rx_req/rx_ack.
// Bit timing comes from external baud-rate enables (tx_clk once per bit, rx_clk
// RX_OVERSAMPLE times per bit).
//
// Frame: start(0), 8 data bits LSB first, [even parity], STOP_BITS stop bits (1).
// Optional feature macro: TT_PARITY_EN (adds the parity bit to both directions; a
// received parity mismatch drops the frame like a framing error).
//
// Ports:
//   clk       in   system clock, all logic on rising edge
//   reset     in   asynchronous, active-low; clears all state
//   tx_clk    in   one-cycle enable per transmit bit time
//   tx_req    in   initiator offers a character on tx_data
//   tx_ack    out  character latched; held until tx_req drops
//   tx_data   in   [7:0] character to send, sampled on acceptance
//   tx_empty  out  holding register and shifter both idle
//   tx_out    out  serial output, idle high
//   rx_clk    in   one-cycle enable, RX_OVERSAMPLE per receive bit time
//   rx_req    in   initiator consumes the held character
//   rx_ack    out  consume done; held until rx_req drops
//   rx_data   out  [7:0] last good received character
//   rx_empty  out  0 = unread character held
//   rx_in     in   serial input, asynchronous to clk
module pdp8_tt_uart #(
   parameter int STOP_BITS     = 2,
   parameter int RX_OVERSAMPLE = 16
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       tx_clk,
   input  logic       tx_req,
   output logic       tx_ack,
   input  logic [7:0] tx_data,
   output logic       tx_empty,
   output logic       tx_out,
   input  logic       rx_clk,
   input  logic       rx_req,
   output logic       rx_ack,
   output logic [7:0] rx_data,
   output logic       rx_empty,
   input  logic       rx_in
);

   localparam int CW = $clog2(RX_OVERSAMPLE);
   localparam logic [CW-1:0] HALF_CNT = CW'(RX_OVERSAMPLE / 2 - 1);
   localparam logic [CW-1:0] FULL_CNT = CW'(RX_OVERSAMPLE - 1);
   localparam logic          STOP_LAST = 1'(STOP_BITS - 1);

`ifdef TT_PARITY_EN
   typedef enum logic [2:0] {TX_IDLE, TX_START, TX_DATA, TX_PAR, TX_STOP} tx_state_t;
   typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_PAR, RX_STOP} rx_state_t;
   logic tx_par_reg, tx_par_next;
   logic rx_par_reg, rx_par_next;
`else
   typedef enum logic [2:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
   typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
`endif

   // ---------------- transmit ----------------
   tx_state_t  tx_state_reg, tx_state_next;
   logic [7:0] tx_shift_reg, tx_shift_next;
   logic [2:0] tx_bits_reg, tx_bits_next;
   logic       tx_stop_reg, tx_stop_next;
   logic       tx_line_reg, tx_line_next;
   logic [7:0] hold_data_reg, hold_data_next;
   logic       hold_full_reg, hold_full_next;
   logic       tx_ack_reg, tx_ack_next;

   always_comb begin
      tx_state_next  = tx_state_reg;
      tx_shift_next  = tx_shift_reg;
      tx_bits_next   = tx_bits_reg;
      tx_stop_next   = tx_stop_reg;
      tx_line_next   = tx_line_reg;
      hold_data_next = hold_data_reg;
      hold_full_next = hold_full_reg;
      tx_ack_next    = tx_ack_reg;
`ifdef TT_PARITY_EN
      tx_par_next    = tx_par_reg;
`endif
      // Handshake: accept only into an empty holding register, once per request.
      if (tx_ack_reg && !tx_req) begin
         tx_ack_next = 1'b0;
      end else if (!tx_ack_reg && tx_req && !hold_full_reg) begin
         hold_data_next = tx_data;
         hold_full_next = 1'b1;
         tx_ack_next    = 1'b1;
      end

      if (tx_clk) begin
         case (tx_state_reg)
            TX_IDLE: begin
               if (hold_full_reg) begin
                  tx_shift_next  = hold_data_reg;
                  hold_full_next = 1'b0;
                  tx_line_next   = 1'b0;
                  tx_state_next  = TX_START;
`ifdef TT_PARITY_EN
                  tx_par_next    = ^hold_data_reg;
`endif
               end
            end
            TX_START: begin
               tx_line_next  = tx_shift_reg[0];
               tx_shift_next = tx_shift_reg >> 1;
               tx_bits_next  = 3'd0;
               tx_state_next = TX_DATA;
            end
            TX_DATA: begin
               // bit 0 went out on the START edge; bits 1..7 on counts 0..6
               if (tx_bits_reg == 3'd7) begin
`ifdef TT_PARITY_EN
                  tx_line_next  = tx_par_reg;
                  tx_state_next = TX_PAR;
`else
                  tx_line_next  = 1'b1;
                  tx_stop_next  = 1'b0;
                  tx_state_next = TX_STOP;
`endif
               end else begin
                  tx_line_next  = tx_shift_reg[0];
                  tx_shift_next = tx_shift_reg >> 1;
                  tx_bits_next  = tx_bits_reg + 3'd1;
               end
            end
`ifdef TT_PARITY_EN
            TX_PAR: begin
               tx_line_next  = 1'b1;
               tx_stop_next  = 1'b0;
               tx_state_next = TX_STOP;
            end
`endif
            TX_STOP: begin
               if (tx_stop_reg == STOP_LAST) begin
                  // a waiting character starts straight away, no idle bit
                  if (hold_full_reg) begin
                     tx_shift_next  = hold_data_reg;
                     hold_full_next = 1'b0;
                     tx_line_next   = 1'b0;
                     tx_state_next  = TX_START;
`ifdef TT_PARITY_EN
                     tx_par_next    = ^hold_data_reg;
`endif
                  end else begin
                     tx_line_next  = 1'b1;
                     tx_state_next = TX_IDLE;
                  end
               end else begin
                  tx_stop_next = 1'b1;
               end
            end
            default: tx_state_next = TX_IDLE;
         endcase
      end
   end

   // ---------------- receive ----------------
   rx_state_t   rx_state_reg, rx_state_next;
   logic [CW-1:0] rx_cnt_reg, rx_cnt_next;
   logic [2:0]  rx_bits_reg, rx_bits_next;
   logic [7:0]  rx_shift_reg, rx_shift_next;
   logic [7:0]  rx_data_reg, rx_data_next;
   logic        rx_empty_reg, rx_empty_next;
   logic        rx_ack_reg, rx_ack_next;
   logic        rx_meta_reg, rx_sync_reg;
   logic        frame_good;

   always_comb begin
      rx_state_next = rx_state_reg;
      rx_cnt_next   = rx_cnt_reg;
      rx_bits_next  = rx_bits_reg;
      rx_shift_next = rx_shift_reg;
      rx_data_next  = rx_data_reg;
      rx_empty_next = rx_empty_reg;
      rx_ack_next   = rx_ack_reg;
      frame_good    = 1'b0;
`ifdef TT_PARITY_EN
      rx_par_next   = rx_par_reg;
`endif
      if (rx_clk) begin
         case (rx_state_reg)
            RX_IDLE: begin
               if (!rx_sync_reg) begin
                  rx_cnt_next   = '0;
                  rx_state_next = RX_START;
               end
            end
            RX_START: begin
               // recheck at mid start bit rejects short glitches
               if (rx_cnt_reg == HALF_CNT) begin
                  rx_cnt_next   = '0;
                  rx_bits_next  = 3'd0;
                  rx_state_next = rx_sync_reg ? RX_IDLE : RX_DATA;
               end else begin
                  rx_cnt_next = rx_cnt_reg + 1'b1;
               end
            end
            RX_DATA: begin
               if (rx_cnt_reg == FULL_CNT) begin
                  rx_cnt_next   = '0;
                  rx_shift_next = {rx_sync_reg, rx_shift_reg[7:1]};
                  if (rx_bits_reg == 3'd7) begin
`ifdef TT_PARITY_EN
                     rx_state_next = RX_PAR;
`else
                     rx_state_next = RX_STOP;
`endif
                  end else begin
                     rx_bits_next = rx_bits_reg + 3'd1;
                  end
               end else begin
                  rx_cnt_next = rx_cnt_reg + 1'b1;
               end
            end
`ifdef TT_PARITY_EN
            RX_PAR: begin
               if (rx_cnt_reg == FULL_CNT) begin
                  rx_cnt_next   = '0;
                  rx_par_next   = rx_sync_reg;
                  rx_state_next = RX_STOP;
               end else begin
                  rx_cnt_next = rx_cnt_reg + 1'b1;
               end
            end
`endif
            RX_STOP: begin
               // return to IDLE at mid stop bit so the next start is not missed
               if (rx_cnt_reg == FULL_CNT) begin
                  rx_cnt_next   = '0;
                  rx_state_next = RX_IDLE;
`ifdef TT_PARITY_EN
                  frame_good    = rx_sync_reg && (rx_par_reg == ^rx_shift_reg);
`else
                  frame_good    = rx_sync_reg;
`endif
               end else begin
                  rx_cnt_next = rx_cnt_reg + 1'b1;
               end
            end
            default: rx_state_next = RX_IDLE;
         endcase
      end

      if (rx_ack_reg && !rx_req) begin
         rx_ack_next = 1'b0;
      end else if (!rx_ack_reg && rx_req) begin
         rx_ack_next   = 1'b1;
         rx_empty_next = 1'b1;
      end
      // a frame completing on the same edge as a read wins
      if (frame_good) begin
         rx_data_next  = rx_shift_reg;
         rx_empty_next = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         tx_state_reg  <= TX_IDLE;
         tx_shift_reg  <= '0;
         tx_bits_reg   <= '0;
         tx_stop_reg   <= 1'b0;
         tx_line_reg   <= 1'b1;
         hold_data_reg <= '0;
         hold_full_reg <= 1'b0;
         tx_ack_reg    <= 1'b0;
         rx_state_reg  <= RX_IDLE;
         rx_cnt_reg    <= '0;
         rx_bits_reg   <= '0;
         rx_shift_reg  <= '0;
         rx_data_reg   <= '0;
         rx_empty_reg  <= 1'b1;
         rx_ack_reg    <= 1'b0;
         rx_meta_reg   <= 1'b1;
         rx_sync_reg   <= 1'b1;
`ifdef TT_PARITY_EN
         tx_par_reg    <= 1'b0;
         rx_par_reg    <= 1'b0;
`endif
      end else begin
         tx_state_reg  <= tx_state_next;
         tx_shift_reg  <= tx_shift_next;
         tx_bits_reg   <= tx_bits_next;
         tx_stop_reg   <= tx_stop_next;
         tx_line_reg   <= tx_line_next;
         hold_data_reg <= hold_data_next;
         hold_full_reg <= hold_full_next;
         tx_ack_reg    <= tx_ack_next;
         rx_state_reg  <= rx_state_next;
         rx_cnt_reg    <= rx_cnt_next;
         rx_bits_reg   <= rx_bits_next;
         rx_shift_reg  <= rx_shift_next;
         rx_data_reg   <= rx_data_next;
         rx_empty_reg  <= rx_empty_next;
         rx_ack_reg    <= rx_ack_next;
         rx_meta_reg   <= rx_in;
         rx_sync_reg   <= rx_meta_reg;
`ifdef TT_PARITY_EN
         tx_par_reg    <= tx_par_next;
         rx_par_reg    <= rx_par_next;
`endif
      end
   end

   assign tx_ack   = tx_ack_reg;
   assign tx_out   = tx_line_reg;
   // an outstanding acknowledge also counts as busy
   assign tx_empty = (tx_state_reg == TX_IDLE) && !hold_full_reg && !tx_ack_reg;
   assign rx_ack   = rx_ack_reg;
   assign rx_data  = rx_data_reg;
   assign rx_empty = rx_empty_reg;

endmodule

// File: tb/tb_pdp8_tt_uart.sv
// tb_pdp8_tt_uart -- self-checking bench for pdp8_tt_uart.
// Transmit frames are recorded one sample per tx_clk and compared with frames built
// from the frame format; receive frames are driven at 16 rx_clk pulses per bit with
// jittered rx_clk spacing and checked against a small holding-register model.
// Build with TT_PARITY_EN defined to exercise the parity variant.
module tb_pdp8_tt_uart;

   localparam int STOP_BITS = 2;
   localparam int OS        = 16;
`ifdef TT_PARITY_EN
   localparam int PAR_BITS = 1;
`else
   localparam int PAR_BITS = 0;
`endif
   localparam int FRAME_LEN = 1 + 8 + PAR_BITS + STOP_BITS;

   logic       clk, reset, tx_clk, tx_req, tx_ack, tx_empty, tx_out;
   logic       rx_clk, rx_req, rx_ack, rx_empty, rx_in;
   logic [7:0] tx_data, rx_data;

   int n_assert = 0;
   int n_fail   = 0;

   logic tx_q[$];
   logic te_q[$];
   logic exp_q[$];
   logic rec_en = 1'b0;
   logic rec_started = 1'b0;

   logic [7:0] exp_rx_data;
   logic       exp_rx_empty;

   pdp8_tt_uart #(.STOP_BITS(STOP_BITS), .RX_OVERSAMPLE(OS)) dut (
      .clk(clk), .reset(reset),
      .tx_clk(tx_clk), .tx_req(tx_req), .tx_ack(tx_ack), .tx_data(tx_data),
      .tx_empty(tx_empty), .tx_out(tx_out),
      .rx_clk(rx_clk), .rx_req(rx_req), .rx_ack(rx_ack), .rx_data(rx_data),
      .rx_empty(rx_empty), .rx_in(rx_in)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // tx bit enable: one pulse every 8 clocks
   initial begin
      int div;
      div = 0;
      tx_clk = 1'b0;
      forever begin
         @(negedge clk);
         div = (div == 7) ? 0 : div + 1;
         tx_clk = (div == 0);
      end
   end

   // rx oversample enable: spacing jitters between 3 and 5 clocks
   initial begin
      int gap;
      gap = 2;
      rx_clk = 1'b0;
      forever begin
         @(negedge clk);
         if (gap == 0) begin
            rx_clk = 1'b1;
            gap = $urandom_range(2, 4);
         end else begin
            rx_clk = 1'b0;
            gap--;
         end
      end
   end

   // transmit recorder: one sample per bit time, starting at the first start bit
   initial begin
      forever begin
         @(posedge clk);
         if (tx_clk && rec_en) begin
            #1;
            if (rec_started || tx_out == 1'b0) begin
               rec_started = 1'b1;
               tx_q.push_back(tx_out);
               te_q.push_back(tx_empty);
            end
         end
      end
   end

   initial begin
      #600000;
      $display("FAIL watchdog: observed timeout expected completion");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // expected serial frame built from the frame format
   task automatic push_frame(input logic [7:0] c);
      exp_q.push_back(1'b0);
      for (int i = 0; i < 8; i++) exp_q.push_back(c[i]);
      if (PAR_BITS == 1) exp_q.push_back(^c);
      for (int i = 0; i < STOP_BITS; i++) exp_q.push_back(1'b1);
   endtask

   task automatic rec_restart();
      rec_en = 1'b0;
      rec_started = 1'b0;
      tx_q.delete();
      te_q.delete();
      exp_q.delete();
      rec_en = 1'b1;
   endtask

   task automatic send_char(input logic [7:0] c);
      int k;
      @(negedge clk);
      tx_req = 1'b1;
      tx_data = c;
      k = 0;
      do begin
         @(negedge clk);
         k++;
      end while (!tx_ack && k < 300);
      chk("tx_ack_rise", tx_ack, 1'b1);
      tx_req = 1'b0;
      tx_data = 8'($urandom);
      @(negedge clk);
      chk("tx_ack_fall", tx_ack, 1'b0);
   endtask

   task automatic wait_samples(input int n);
      int k;
      k = 0;
      while (tx_q.size() < n && k < 3000) begin
         @(negedge clk);
         k++;
      end
      chk("tx_sample_count", (tx_q.size() >= n), 1'b1);
   endtask

   task automatic check_stream(input string tag);
      int n;
      n = exp_q.size();
      wait_samples(n + 1);
      for (int i = 0; i < n && i < tx_q.size(); i++) begin
         chk($sformatf("%s_bit%0d", tag, i), tx_q[i], exp_q[i]);
         chk($sformatf("%s_busy%0d", tag, i), te_q[i], 1'b0);
      end
      if (tx_q.size() > n) begin
         chk($sformatf("%s_idle_line", tag), tx_q[n], 1'b1);
         chk($sformatf("%s_idle_empty", tag), te_q[n], 1'b1);
      end
   endtask

   task automatic rx_pulses(input int n);
      repeat (n) begin
         @(posedge clk);
         while (!rx_clk) @(posedge clk);
      end
      #1;
   endtask

   task automatic drive_frame(input logic [7:0] c, input logic stop_val, input logic par_val);
      rx_pulses(1);
      rx_in = 1'b0;
      rx_pulses(OS);
      for (int i = 0; i < 8; i++) begin
         rx_in = c[i];
         rx_pulses(OS);
      end
`ifdef TT_PARITY_EN
      rx_in = par_val;
      rx_pulses(OS);
`else
      if (par_val) rx_in = 1'b1;
`endif
      rx_in = stop_val;
      rx_pulses(OS);
      rx_in = 1'b1;
      rx_pulses(OS);
      if (stop_val) begin
`ifdef TT_PARITY_EN
         if (par_val == ^c) begin
            exp_rx_data = c;
            exp_rx_empty = 1'b0;
         end
`else
         exp_rx_data = c;
         exp_rx_empty = 1'b0;
`endif
      end
   endtask

   task automatic check_rx(input string tag);
      @(negedge clk);
      chk({tag, "_empty"}, rx_empty, exp_rx_empty);
      chk({tag, "_data"}, rx_data, exp_rx_data);
   endtask

   task automatic do_read(input string tag);
      @(negedge clk);
      rx_req = 1'b1;
      @(negedge clk);
      exp_rx_empty = 1'b1;
      chk({tag, "_ack"}, rx_ack, 1'b1);
      chk({tag, "_empty"}, rx_empty, 1'b1);
      chk({tag, "_data"}, rx_data, exp_rx_data);
      rx_req = 1'b0;
      @(negedge clk);
      chk({tag, "_ack_fall"}, rx_ack, 1'b0);
   endtask

   initial begin
      logic [7:0] chars [8];
      logic [7:0] c;
      reset = 1'b0;
      tx_req = 1'b0;
      tx_data = 8'h00;
      rx_req = 1'b0;
      rx_in = 1'b1;
      exp_rx_data = 8'h00;
      exp_rx_empty = 1'b1;

      // reset state
      repeat (3) @(negedge clk);
      chk("rst_tx_out", tx_out, 1'b1);
      chk("rst_tx_empty", tx_empty, 1'b1);
      chk("rst_tx_ack", tx_ack, 1'b0);
      chk("rst_rx_ack", rx_ack, 1'b0);
      chk("rst_rx_empty", rx_empty, 1'b1);
      chk("rst_rx_data", rx_data, 8'h00);
      reset = 1'b1;
      repeat (3) @(negedge clk);
      chk("idle_tx_out", tx_out, 1'b1);

      // reset mid-frame: line low on bit 3 of 0x55, reset forces idle at once
      rec_restart();
      send_char(8'h55);
      wait_samples(5);
      chk("pre_reset_bit3", tx_out, 1'b0);
      #2;
      reset = 1'b0;
      #1;
      chk("midrst_tx_out", tx_out, 1'b1);
      chk("midrst_tx_empty", tx_empty, 1'b1);
      chk("midrst_tx_ack", tx_ack, 1'b0);
      @(negedge clk);
      reset = 1'b1;
      repeat (20) @(negedge clk);
      chk("post_rst_tx_out", tx_out, 1'b1);

      // single character 0x41: ack on the next edge, then the frame
      rec_restart();
      push_frame(8'h41);
      @(negedge clk);
      tx_req = 1'b1;
      tx_data = 8'h41;
      @(negedge clk);
      chk("a41_ack", tx_ack, 1'b1);
      chk("a41_empty", tx_empty, 1'b0);
      tx_req = 1'b0;
      tx_data = 8'hFF;
      @(negedge clk);
      chk("a41_ack_fall", tx_ack, 1'b0);
      check_stream("a41");
`ifdef TT_PARITY_EN
      // 0x03 has two ones: parity bit is 0
      rec_restart();
      push_frame(8'h03);
      send_char(8'h03);
      check_stream("p03");
      if (tx_q.size() > 9) chk("p03_parity", tx_q[9], 1'b0);
`endif

      // back-to-back: CR, LF and random characters with no idle bit between frames
      rec_restart();
      chars[0] = 8'h0D;
      chars[1] = 8'h0A;
      for (int i = 2; i < 8; i++) chars[i] = 8'($urandom);
      for (int i = 0; i < 8; i++) push_frame(chars[i]);
      for (int i = 0; i < 8; i++) send_char(chars[i]);
      check_stream("b2b");
      rec_en = 1'b0;

      // receive 0x8D, then read it
      drive_frame(8'h8D, 1'b1, ^8'h8D);
      check_rx("rx8d");
      do_read("rd8d");
      check_rx("rx8d_after_read");

      // short low glitch: no frame
      rx_pulses(1);
      rx_in = 1'b0;
      rx_pulses(OS / 4);
      rx_in = 1'b1;
      rx_pulses(3 * OS);
      check_rx("glitch");

      // stop bit 0: frame dropped
      drive_frame(8'h5A, 1'b0, ^8'h5A);
      check_rx("framing");

      // read while empty still acknowledges, nothing changes
      do_read("rd_empty");

`ifdef TT_PARITY_EN
      drive_frame(8'h07, 1'b1, 1'b0);
      check_rx("par07_bad");
      drive_frame(8'h07, 1'b1, 1'b1);
      check_rx("par07_good");
      do_read("rd_par07");
`endif

      // random frames, some with bad stop bits, reads skipped at random (overrun)
      for (int i = 0; i < 6; i++) begin
         c = 8'($urandom);
         drive_frame(c, ($urandom_range(0, 3) != 0), ^c);
         check_rx($sformatf("rnd%0d", i));
         if ($urandom_range(0, 1) == 1) do_read($sformatf("rnd_rd%0d", i));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
